// File: rtl/neuron_stage_sequencer_pkg.sv
// Shared types and default constants for the neuron stage sequencer.
package neuron_stage_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seqState_t;

    localparam int DEFAULT_NUM_TAPS = 32;
    localparam int DEFAULT_PIPE_LAT = 4;

    // Operand format of the downstream MAC datapath.
    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  expo;
    } float_24_8;

endpackage

// File: rtl/neuron_stage_sequencer_delay.sv
// Fixed-latency valid line: dout is din delayed by exactly PIPE_LAT cycles.
module neuronValidDelay #(
    parameter int PIPE_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [PIPE_LAT:1] vldPipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vldPipe <= '0;
        end else begin
            vldPipe[1] <= din;
            for (int i = 2; i <= PIPE_LAT; i++)
                vldPipe[i] <= vldPipe[i-1];
        end
    end

    assign dout = vldPipe[PIPE_LAT];

endmodule

// File: rtl/neuron_stage_sequencer.sv
// Sequences tap/data fetches for a batch of neurons and tracks the result latency.
module neuron_stage_sequencer
    import neuron_stage_sequencer_pkg::*;
#(
    parameter int NUM_TAPS = DEFAULT_NUM_TAPS,
    parameter int ADDR_W   = 16,
    parameter int PIPE_LAT = DEFAULT_PIPE_LAT,
    localparam int TAP_W   = $clog2(NUM_TAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] numNeurons,
    input  logic              hold,
    output logic              rdEn,
    output logic [ADDR_W-1:0] rdAddr,
    output logic [TAP_W-1:0]  tapIdx,
    output logic [ADDR_W-1:0] biasAddr,
    output logic              valid,
    output logic              outValid,
    output logic              busy,
    output logic              done
);

    localparam int DC_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(PIPE_LAT - 1);

    seqState_t         state, stateNxt;
    logic              rdEnNxt, validNxt, busyNxt, doneNxt;
    logic [ADDR_W-1:0] rdAddrNxt, biasAddrNxt, lastNeuron, lastNeuronNxt;
    logic [TAP_W-1:0]  tapIdxNxt;
    logic [DC_W-1:0]   drainCnt, drainCntNxt;
    logic              lastTap;

    assign lastTap = (tapIdx == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rdEn       <= 1'b0;
            rdAddr     <= '0;
            tapIdx     <= '0;
            biasAddr   <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            lastNeuron <= '0;
            drainCnt   <= '0;
        end else begin
            state      <= stateNxt;
            rdEn       <= rdEnNxt;
            rdAddr     <= rdAddrNxt;
            tapIdx     <= tapIdxNxt;
            biasAddr   <= biasAddrNxt;
            valid      <= validNxt;
            busy       <= busyNxt;
            done       <= doneNxt;
            lastNeuron <= lastNeuronNxt;
            drainCnt   <= drainCntNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (start) stateNxt = (numNeurons == '0) ? DONE : RUN;
            RUN:     if (rdEn && valid && biasAddr == lastNeuron) stateNxt = DRAIN;
            DRAIN:   if (drainCnt == DRAIN_LAST) stateNxt = DONE;
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Computes the next registered output values; every port comes from a flop.
    always_comb begin
        rdEnNxt       = 1'b0;
        rdAddrNxt     = rdAddr;
        tapIdxNxt     = tapIdx;
        biasAddrNxt   = biasAddr;
        lastNeuronNxt = lastNeuron;
        drainCntNxt   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    rdAddrNxt     = '0;
                    tapIdxNxt     = '0;
                    biasAddrNxt   = '0;
                    lastNeuronNxt = numNeurons - 1'b1;
                    rdEnNxt       = (numNeurons != '0);
                end
            end
            RUN: begin
                if (rdEn) begin
                    tapIdxNxt = tapIdx + 1'b1;
                    rdAddrNxt = rdAddr + 1'b1;
                    if (lastTap) biasAddrNxt = biasAddr + 1'b1;
                end
                // hold only bites when the next fetch would open a neuron
                if (stateNxt == RUN) rdEnNxt = (tapIdxNxt != '0) || !hold;
            end
            DRAIN: drainCntNxt = drainCnt + 1'b1;
            default: ;
        endcase
        validNxt = rdEnNxt && (tapIdxNxt == '1);
        busyNxt  = (stateNxt == RUN) || (stateNxt == DRAIN);
        doneNxt  = (stateNxt == DONE);
    end

    neuronValidDelay #(
        .PIPE_LAT(PIPE_LAT)
    ) uValidDelay (
        .clk  (clk),
        .reset(reset),
        .din  (valid),
        .dout (outValid)
    );

endmodule

// File: tb/tb_neuron_stage_sequencer.sv
// Directed bench for neuron_stage_sequencer at default parameters.
module tb_neuron_stage_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, hold;
    logic [15:0] numNeurons;
    logic        rdEn, valid, outValid, busy, done;
    logic [15:0] rdAddr, biasAddr;
    logic [4:0]  tapIdx;

    int tests = 0;
    int fails = 0;

    neuron_stage_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .numNeurons(numNeurons), .hold(hold),
        .rdEn(rdEn), .rdAddr(rdAddr), .tapIdx(tapIdx), .biasAddr(biasAddr),
        .valid(valid), .outValid(outValid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns at the negedge observing the first cycle after start was sampled.
    task automatic launch(input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        numNeurons = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; hold = 1'b0; numNeurons = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({rdEn, valid, outValid, busy, done, rdAddr, tapIdx, biasAddr} !== '0) begin
            fails++;
            $display("FAIL reset_state: got flags %b addr %0d tap %0d bias %0d want all 0",
                     {rdEn, valid, outValid, busy, done}, rdAddr, tapIdx, biasAddr);
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            tests++;
            if ({rdEn, valid, outValid, busy, done, rdAddr, tapIdx, biasAddr} !== '0) begin
                fails++;
                $display("FAIL post_release_idle: got flags %b addr %0d want all 0",
                         {rdEn, valid, outValid, busy, done}, rdAddr);
            end
        end
    endtask

    task automatic test_two_neurons;
        logic [4:0] expF;
        launch(16'd2);
        for (int k = 1; k <= 72; k++) begin
            expF = {k <= 64, k == 32 || k == 64, k == 36 || k == 68, k <= 68, k == 69};
            tests++;
            if ({rdEn, valid, outValid, busy, done} !== expF) begin
                fails++;
                $display("FAIL two_neurons_flags k=%0d: got %b want %b",
                         k, {rdEn, valid, outValid, busy, done}, expF);
            end
            if (k <= 64) begin
                tests++;
                if (rdAddr !== 16'(k - 1) || tapIdx !== 5'((k - 1) % 32) || biasAddr !== 16'((k - 1) / 32)) begin
                    fails++;
                    $display("FAIL two_neurons_addr k=%0d: got addr %0d tap %0d bias %0d want %0d %0d %0d",
                             k, rdAddr, tapIdx, biasAddr, k - 1, (k - 1) % 32, (k - 1) / 32);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold_boundary;
        int bubbles = 0, valids = 0, outVs = 0, addrErr = 0, doneK = 0, resumeAddr = -1;
        logic prevBubble = 1'b0;
        logic [15:0] expAddr = '0;
        launch(16'd3);
        for (int k = 1; k <= 200 && doneK == 0; k++) begin
            if (rdEn) begin
                if (rdAddr !== expAddr) addrErr++;
                if (prevBubble && resumeAddr < 0) resumeAddr = int'(rdAddr);
                expAddr++;
            end
            prevBubble = busy && !rdEn && biasAddr < 16'd3;
            if (prevBubble) bubbles++;
            if (valid) valids++;
            if (outValid) outVs++;
            if (done) doneK = k;
            hold = (k >= 32 && k <= 36);
            @(negedge clk);
        end
        hold = 1'b0;
        tests++;
        if (bubbles != 5) begin fails++; $display("FAIL hold_bubbles: got %0d want 5", bubbles); end
        tests++;
        if (resumeAddr != 32) begin fails++; $display("FAIL hold_resume_addr: got %0d want 32", resumeAddr); end
        tests++;
        if (valids != 3 || outVs != 3) begin
            fails++; $display("FAIL hold_valid_count: got %0d/%0d want 3/3", valids, outVs);
        end
        tests++;
        if (addrErr != 0) begin fails++; $display("FAIL hold_addr_contig: got %0d errors want 0", addrErr); end
        tests++;
        if (doneK != 106) begin fails++; $display("FAIL hold_done_cycle: got %0d want 106", doneK); end
    endtask

    task automatic test_hold_mid;
        int bubbles = 0, firstBubble = 0, rdCnt = 0, addrErr = 0, valids = 0, doneK = 0;
        launch(16'd2);
        for (int k = 1; k <= 200 && doneK == 0; k++) begin
            if (rdEn && k <= 32) begin
                rdCnt++;
                if (rdAddr !== 16'(k - 1)) addrErr++;
            end
            if (busy && !rdEn && biasAddr < 16'd2) begin
                bubbles++;
                if (firstBubble == 0) firstBubble = k;
            end
            if (valid) valids++;
            if (done) doneK = k;
            hold = (k >= 11 && k <= 33);
            @(negedge clk);
        end
        hold = 1'b0;
        tests++;
        if (rdCnt != 32 || addrErr != 0) begin
            fails++; $display("FAIL hold_mid_contig: got %0d fetches %0d errors want 32 0", rdCnt, addrErr);
        end
        tests++;
        if (firstBubble != 33 || bubbles != 2) begin
            fails++; $display("FAIL hold_mid_bubble: got first %0d count %0d want 33 2", firstBubble, bubbles);
        end
        tests++;
        if (valids != 2 || doneK != 71) begin
            fails++; $display("FAIL hold_mid_end: got valids %0d done %0d want 2 71", valids, doneK);
        end
    endtask

    task automatic test_zero;
        launch(16'd0);
        for (int k = 1; k <= 6; k++) begin
            tests++;
            if ({rdEn, valid, outValid, busy, done} !== {4'b0000, k == 1}) begin
                fails++;
                $display("FAIL zero_neurons k=%0d: got %b want %b",
                         k, {rdEn, valid, outValid, busy, done}, {4'b0000, k == 1});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort;
        int n = 0, stray = 0;
        logic [3:0] expF;
        launch(16'd4);
        while (rdAddr !== 16'd40 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (rdAddr !== 16'd40) begin fails++; $display("FAIL abort_reach_40: got %0d want 40", rdAddr); end
        reset = 1'b1;
        #1;
        tests++;
        if ({rdEn, valid, outValid, busy, done, rdAddr, tapIdx, biasAddr} !== '0) begin
            fails++;
            $display("FAIL abort_async_clear: got flags %b addr %0d want all 0",
                     {rdEn, valid, outValid, busy, done}, rdAddr);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rdEn || outValid || done || busy || valid) stray++;
        end
        tests++;
        if (stray != 0) begin fails++; $display("FAIL abort_no_activity: got %0d active cycles want 0", stray); end
        launch(16'd1);
        for (int k = 1; k <= 40; k++) begin
            expF = {k <= 32, k == 32, k == 36, k == 37};
            tests++;
            if ({rdEn, valid, outValid, done} !== expF || (rdEn && rdAddr !== 16'(k - 1))) begin
                fails++;
                $display("FAIL abort_restart k=%0d: got %b addr %0d want %b addr %0d",
                         k, {rdEn, valid, outValid, done}, rdAddr, expF, k - 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignored_start;
        int valids = 0, rdCnt = 0, doneK = 0;
        launch(16'd2);
        for (int k = 1; k <= 110; k++) begin
            if (k <= 69) begin
                if (valid) valids++;
                if (rdEn) rdCnt++;
            end
            if (k == 10) begin start = 1'b1; numNeurons = 16'd5; end
            if (k == 11) begin start = 1'b0; numNeurons = 16'd7; end
            if (k == 69) begin
                tests++;
                if (done !== 1'b1) begin fails++; $display("FAIL ignore_done_cycle: got %b want 1", done); end
                start = 1'b1;
                numNeurons = 16'd1;
            end
            if (k == 70) begin
                tests++;
                if ({rdEn, busy, done} !== 3'b000) begin
                    fails++; $display("FAIL ignore_start_in_done: got %b want 000", {rdEn, busy, done});
                end
            end
            if (k == 71) begin
                start = 1'b0;
                tests++;
                if ({rdEn, busy} !== 2'b11 || rdAddr !== 16'd0) begin
                    fails++; $display("FAIL idle_start_accepted: got %b addr %0d want 11 addr 0", {rdEn, busy}, rdAddr);
                end
            end
            if (k > 71 && done && doneK == 0) doneK = k;
            @(negedge clk);
        end
        tests++;
        if (valids != 2 || rdCnt != 64) begin
            fails++; $display("FAIL ignore_count: got valids %0d fetches %0d want 2 64", valids, rdCnt);
        end
        tests++;
        if (doneK != 107) begin fails++; $display("FAIL ignore_second_done: got %0d want 107", doneK); end
    endtask

    initial begin
        test_reset();
        test_two_neurons();
        test_hold_boundary();
        test_hold_mid();
        test_zero();
        test_reset_abort();
        test_ignored_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/neuron_stage_sequencer.md
NEURON_STAGE_SEQUENCER -- requirements
Module: neuronStageSequencer

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 32: taps per neuron, power of two, 2..64.
REQ-002 SHALL have parameter ADDR_W, default 16: width of all address and count ports.
REQ-003 SHALL have parameter PIPE_LAT, default 4: cycles from neuronStage valid to dataOut_0 valid.
REQ-004 SHALL have port clk, input, 1, single rising-edge clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, begin-batch pulse.
REQ-007 SHALL have port numNeurons, input, ADDR_W, neurons in the batch, sampled on an accepted start.
REQ-008 SHALL have port hold, input, 1, request to insert bubbles between neurons.
REQ-009 SHALL have port rdEn, output, 1, data/tap fetch strobe.
REQ-010 SHALL have port rdAddr, output, ADDR_W, data/tap memory address.
REQ-011 SHALL have port tapIdx, output, log2(NUM_TAPS), current tap within the neuron.
REQ-012 SHALL have port biasAddr, output, ADDR_W, current neuron index for bias fetch.
REQ-013 SHALL have port valid, output, 1, neuronStage valid, marking the last tap of a neuron.
REQ-014 SHALL have port outValid, output, 1, dataOut_0 capture strobe.
REQ-015 SHALL have ports busy and done, output, 1 each: busy is high in RUN or DRAIN; done is a one-cycle completion pulse.

Function
REQ-016 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-017 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-018 Start with numNeurons=0 SHALL go IDLE->DONE, with no rdEn and no valid.
REQ-019 Start with numNeurons>0 SHALL go IDLE->RUN; the first rdEn is in cycle t+1 for start in cycle t, with rdAddr=0, tapIdx=0 and biasAddr=0.
REQ-020 In RUN, each cycle with rdEn=1 SHALL advance tapIdx by 1, wrap it at NUM_TAPS, and advance rdAddr by 1 modulo 2^ADDR_W.
REQ-021 valid SHALL be asserted in the same cycle as rdEn when tapIdx=NUM_TAPS-1, and only then.
REQ-022 biasAddr SHALL increment in the cycle after each valid.
REQ-023 hold SHALL be honoured only at a neuron boundary (tapIdx=0): while it is high there, rdEn=0, valid=0 and all counters are frozen.
REQ-024 hold SHALL be ignored mid-neuron, so each neuron's taps are always contiguous.
REQ-025 After the valid for neuron numNeurons-1, the block SHALL go RUN->DRAIN.
REQ-026 outValid SHALL equal valid delayed by exactly PIPE_LAT cycles through a shift register that hold does not affect.
REQ-027 DRAIN SHALL exit to DONE in the cycle after the final outValid.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-029 Start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-030 All outputs SHALL be registered.
REQ-031 rdAddr SHALL equal biasAddr*NUM_TAPS+tapIdx whenever rdEn=1.

Reset
REQ-032 Reset SHALL force IDLE, rdEn=0, rdAddr=0, tapIdx=0, biasAddr=0, valid=0, outValid=0, busy=0 and done=0.
REQ-033 Reset SHALL clear the latency shift register.
REQ-034 Reset asserted mid-RUN or mid-DRAIN SHALL abort the batch, with no outValid or done produced after its release.
REQ-035 No output SHALL toggle in the first cycle after reset release unless start was sampled.

Structure
REQ-036 The state encoding and the default NUM_TAPS/PIPE_LAT constants SHALL live in a shared package alongside float_24_8.
REQ-037 The latency line SHALL be a sub-module neuronValidDelay (parameter PIPE_LAT, 1-bit in/out, async reset).
REQ-038 No arithmetic beyond counters is permitted; no float_24_8 datapath SHALL be inside this block.

Verification
REQ-039 Directed test: numNeurons=2 at defaults -> rdEn high for 64 consecutive cycles; valid at rdAddr 31 and 63; outValid 4 cycles after each valid; done 1 cycle after the second outValid.
REQ-040 Directed test: numNeurons=3 with hold high for 5 cycles starting at tapIdx=0 of neuron 1 -> exactly 5 bubble cycles; rdAddr resumes at 32; total valids = 3.
REQ-041 Directed test: hold asserted at tapIdx=10 -> no bubble until the next boundary; rdAddr is contiguous 0..31.
REQ-042 Directed test: numNeurons=0 -> done pulses at t+1; rdEn, valid and outValid stay 0; busy stays 0.
REQ-043 Directed test: reset asserted at rdAddr=40 during a 4-neuron batch -> all outputs 0 within the same cycle; no outValid after release; a new start with numNeurons=1 gives rdAddr 0..31.
REQ-044 Directed test: start re-pulsed during RUN and during DONE -> ignored; numNeurons changed mid-batch -> ignored; exactly the sampled neuron count is issued.
